// File: rtl/mem_arbiter_if.sv
// Bundle of requester, response and memory-card signals for mem_arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface mem_arbiter_if;
    logic       clr_req;
    logic       clr_done;

    logic       p0_valid;
    logic       p0_ready;
    logic       p0_we;
    logic [3:0] p0_addr;
    logic [7:0] p0_wdata;
    logic       p0_resp_valid;
    logic       p0_resp_err;

    logic       p1_valid;
    logic       p1_ready;
    logic       p1_we;
    logic [3:0] p1_addr;
    logic [7:0] p1_wdata;
    logic       p1_resp_valid;
    logic       p1_resp_err;

    logic [7:0] resp_rdata;

    logic       mem_rw;
    logic       mem_clr;
    logic [3:0] mem_address;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
    logic       mem_out_valid;
    logic       busy;

    modport slave (
        input  clr_req, p0_valid, p0_we, p0_addr, p0_wdata,
        input  p1_valid, p1_we, p1_addr, p1_wdata, mem_data_out, mem_out_valid,
        output clr_done, p0_ready, p0_resp_valid, p0_resp_err,
        output p1_ready, p1_resp_valid, p1_resp_err, resp_rdata,
        output mem_rw, mem_clr, mem_address, mem_data_in, busy
    );

    modport master (
        output clr_req, p0_valid, p0_we, p0_addr, p0_wdata,
        output p1_valid, p1_we, p1_addr, p1_wdata, mem_data_out, mem_out_valid,
        input  clr_done, p0_ready, p0_resp_valid, p0_resp_err,
        input  p1_ready, p1_resp_valid, p1_resp_err, resp_rdata,
        input  mem_rw, mem_clr, mem_address, mem_data_in, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared 16 x 8 data memory,
// with read timeout and a clear sequencer.
module mem_arbiter #(
    parameter int unsigned TIMEOUT    = 4,
    parameter int unsigned CLR_CYCLES = 2
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StClear    = 3'd1;
    localparam logic [2:0] StWrite    = 3'd2;
    localparam logic [2:0] StReadWait = 3'd3;
    localparam logic [2:0] StResp     = 3'd4;

    localparam logic [3:0] TimeoutLast = 4'(TIMEOUT - 1);
    localparam logic [3:0] ClrLast     = 4'(CLR_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       gnt_q, gnt_d;
    logic       we_q, we_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;
    logic [3:0] cnt_q, cnt_d;
    logic       clr_done_q, clr_done_d;

    logic idle, take0, take1, resp;

    assign idle = (state_q == StIdle);
    // last_grant_q == 1 means port 1 was served last, so port 0 wins a tie.
    assign take0 = idle & ~bus.clr_req & bus.p0_valid & (~bus.p1_valid | last_grant_q);
    assign take1 = idle & ~bus.clr_req & bus.p1_valid & (~bus.p0_valid | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        clr_done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (bus.clr_req) begin
                    state_d = StClear;
                end else if (take0 || take1) begin
                    gnt_d        = take1;
                    last_grant_d = take1;
                    we_d         = take1 ? bus.p1_we : bus.p0_we;
                    addr_d       = take1 ? bus.p1_addr : bus.p0_addr;
                    if (we_d) begin
                        wdata_d = take1 ? bus.p1_wdata : bus.p0_wdata;
                    end
                    state_d = we_d ? StWrite : StReadWait;
                end
            end
            StClear: begin
                if (cnt_q == ClrLast) begin
                    state_d    = StIdle;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWrite: begin
                err_d   = 1'b0;
                state_d = StResp;
            end
            StReadWait: begin
                // Valid data takes precedence over a timeout on the same cycle.
                if (bus.mem_out_valid) begin
                    rdata_d = bus.mem_data_out;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    rdata_d = 8'h00;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 4'd0;
            wdata_q      <= 8'd0;
            rdata_q      <= 8'd0;
            err_q        <= 1'b0;
            cnt_q        <= 4'd0;
            clr_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            clr_done_q   <= clr_done_d;
        end
    end

    assign resp = (state_q == StResp);

    assign bus.p0_ready      = take0;
    assign bus.p1_ready      = take1;
    assign bus.p0_resp_valid = resp & ~gnt_q;
    assign bus.p1_resp_valid = resp & gnt_q;
    assign bus.p0_resp_err   = resp & ~gnt_q & err_q;
    assign bus.p1_resp_err   = resp & gnt_q & err_q;
    assign bus.resp_rdata    = rdata_q;
    assign bus.mem_rw        = (state_q == StWrite);
    assign bus.mem_clr       = (state_q == StClear);
    assign bus.mem_address   = addr_q;
    assign bus.mem_data_in   = wdata_q;
    assign bus.busy          = ~idle;
    assign bus.clr_done      = clr_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts grant
// order, response timing, read data and error flags.
module tb_mem_arbiter;

    localparam int unsigned TIMEOUT    = 4;
    localparam int unsigned CLR_CYCLES = 2;

    logic clk = 1'b0;
    logic reset;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .TIMEOUT    (TIMEOUT),
        .CLR_CYCLES (CLR_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory card: written by the arbiter, read back combinationally.
    logic [7:0] mem_img [16] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.mem_clr) begin
            for (int i = 0; i < 16; i++) mem_img[i] <= 8'h00;
        end else if (bus.mem_rw) begin
            mem_img[bus.mem_address] <= bus.mem_data_in;
        end
    end
    assign bus.mem_data_out = mem_img[bus.mem_address];

    // Reference model state.
    logic [7:0] ref_mem [16];
    int         last_g;
    int         n_checks;
    int         n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request phase plus the cycles up to and just past the response.
    // k = cycle within READ_WAIT at which memory answers (0 or > TIMEOUT: never).
    task automatic run_txn(input bit v0, input bit v1, input bit we0, input bit we1,
                           input logic [3:0] a0, input logic [3:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1, input int k);
        int         w;
        int         er;
        bit         we;
        bit         hit;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
        w   = (v0 && v1) ? ((last_g == 1) ? 0 : 1) : (v0 ? 0 : 1);
        we  = (w == 1) ? we1 : we0;
        a   = (w == 1) ? a1 : a0;
        d   = (w == 1) ? d1 : d0;
        hit = !we && (k >= 1) && (k <= int'(TIMEOUT));
        er  = we ? 2 : (hit ? k + 1 : int'(TIMEOUT) + 1);
        exp_rd = hit ? ref_mem[a] : 8'h00;

        @(negedge clk);
        bus.p0_valid = v0; bus.p0_we = we0; bus.p0_addr = a0; bus.p0_wdata = d0;
        bus.p1_valid = v1; bus.p1_we = we1; bus.p1_addr = a1; bus.p1_wdata = d1;
        #1;
        check_eq("grant", {30'd0, bus.p1_ready, bus.p0_ready}, (w == 1) ? 32'd2 : 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        last_g = w;
        for (int c = 1; c <= er + 1; c++) begin
            if (c > 1) @(negedge clk);
            bus.mem_out_valid = hit && (c == k);
            #1;
            check_eq("busy", {31'd0, bus.busy}, {31'd0, c <= er});
            check_eq("mem_rw", {31'd0, bus.mem_rw}, {31'd0, we && c == 1});
            if (we && c == 1) begin
                check_eq("wr_addr", {28'd0, bus.mem_address}, {28'd0, a});
                check_eq("wr_data", {24'd0, bus.mem_data_in}, {24'd0, d});
            end
            if (!we && c < er) check_eq("rd_addr", {28'd0, bus.mem_address}, {28'd0, a});
            check_eq("resp_valid", {30'd0, bus.p1_resp_valid, bus.p0_resp_valid},
                     (c == er) ? ((w == 1) ? 32'd2 : 32'd1) : 32'd0);
            if (c == er) begin
                check_eq("resp_err", {31'd0, (w == 1) ? bus.p1_resp_err : bus.p0_resp_err},
                         {31'd0, !we && !hit});
                if (!we) check_eq("rdata", {24'd0, bus.resp_rdata}, {24'd0, exp_rd});
            end
        end
        bus.mem_out_valid = 1'b0;
        if (we) ref_mem[a] = d;
    endtask

    task automatic do_clear(input bit hold_p0);
        @(negedge clk);
        bus.clr_req  = 1'b1;
        bus.p0_valid = hold_p0;
        bus.p0_we    = 1'b0;
        #1;
        check_eq("clr_ready", {30'd0, bus.p1_ready, bus.p0_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.clr_req = 1'b0;
        for (int c = 1; c <= int'(CLR_CYCLES) + 1; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            check_eq("mem_clr", {31'd0, bus.mem_clr}, {31'd0, c <= int'(CLR_CYCLES)});
            check_eq("clr_done", {31'd0, bus.clr_done}, {31'd0, c == int'(CLR_CYCLES) + 1});
            check_eq("clr_busy", {31'd0, bus.busy}, {31'd0, c <= int'(CLR_CYCLES)});
            check_eq("clr_p0_ready", {31'd0, bus.p0_ready},
                     {31'd0, hold_p0 && c == int'(CLR_CYCLES) + 1});
        end
        bus.p0_valid = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic reset_mid_read();
        @(negedge clk);
        bus.p0_valid = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 4'd5;
        bus.p1_valid = 1'b0;
        #1;
        check_eq("mr_ready", {31'd0, bus.p0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.p0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("mr_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("mr_mem_rw", {31'd0, bus.mem_rw}, 32'd0);
        check_eq("mr_addr", {28'd0, bus.mem_address}, 32'd0);
        check_eq("mr_rdata", {24'd0, bus.resp_rdata}, 32'd0);
        last_g = 1;
        for (int c = 0; c < 4; c++) begin
            check_eq("mr_no_resp", {30'd0, bus.p1_resp_valid, bus.p0_resp_valid}, 32'd0);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        last_g   = 1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        bus.clr_req = 1'b0; bus.mem_out_valid = 1'b0;
        bus.p0_valid = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 4'd0; bus.p0_wdata = 8'd0;
        bus.p1_valid = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 4'd0; bus.p1_wdata = 8'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_outs", {26'd0, bus.mem_rw, bus.mem_clr, bus.clr_done, bus.p0_resp_valid,
                 bus.p1_resp_valid, bus.p0_ready | bus.p1_ready}, 32'd0);
        check_eq("rst_addr", {28'd0, bus.mem_address}, 32'd0);
        check_eq("rst_wdata", {24'd0, bus.mem_data_in}, 32'd0);
        check_eq("rst_rdata", {24'd0, bus.resp_rdata}, 32'd0);

        // Continuous ties from reset alternate p0, p1, p0, p1.
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 1);
        end
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 8'hA5, 8'h00, 0);
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 8'h00, 8'h00, 1);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 8'h00, 8'h00, 0);
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 8'h00, 8'h00, int'(TIMEOUT));
        do_clear(1'b1);
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 8'h00, 8'h00, 2);
        reset_mid_read();
        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 4'd8, 8'h3C, 8'hC3, 0);

        for (int i = 0; i < 60; i++) begin
            int v;
            if ($urandom_range(0, 7) == 0) begin
                do_clear(1'($urandom_range(0, 1)));
            end else begin
                v = int'($urandom_range(1, 3));
                run_txn(v[0], v[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                        int'($urandom_range(0, TIMEOUT + 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
